// File: rtl/hazard_sched.sv
// hazard_sched: bypass selects, load-use stall and mul/div sequencing for the 5-stage core.
// Fields: opcode [31:27], rd [26:22], rs1 [21:17], rs2 [16:12], ALU op [6:2].
module hazard_sched #(
    parameter int MD_LATENCY = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    input  logic [31:0] xm_insn,
    input  logic [31:0] mw_insn,
    output logic        stall_fd,
    output logic        stall_dx,
    output logic        bubble_dx,
    output logic        md_start,
    output logic        md_op,
    output logic        md_busy,
    output logic        md_result_valid,
    output logic [1:0]  sel_a,
    output logic [1:0]  sel_b
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     r_state;
    logic [5:0] r_cnt;

    // Register 0 doubles as "no register", since r0 never forwards or stalls.
    function automatic logic [4:0] dest(input logic [31:0] i);
        logic [4:0] op;
        op = i[31:27];
        return (op == 5'b00000 || op == 5'b00101 || op == 5'b01000) ? i[26:22] :
               (op == 5'b00011) ? 5'd31 :
               (op == 5'b10101) ? 5'd30 : 5'd0;
    endfunction

    function automatic logic [4:0] src_a(input logic [31:0] i);
        logic [4:0] op;
        op = i[31:27];
        return (op == 5'b00000 || op == 5'b00101 || op == 5'b00111 || op == 5'b01000 ||
                op == 5'b00010 || op == 5'b00110) ? i[21:17] :
               (op == 5'b00100) ? i[26:22] :
               (op == 5'b10110) ? 5'd30 : 5'd0;
    endfunction

    function automatic logic [4:0] src_b(input logic [31:0] i);
        logic [4:0] op;
        op = i[31:27];
        return (op == 5'b00000) ? i[16:12] :
               (op == 5'b00111 || op == 5'b00010 || op == 5'b00110) ? i[26:22] : 5'd0;
    endfunction

    logic [4:0] w_xm_dst, w_mw_dst, w_dx_a, w_dx_b, w_fd_a, w_fd_b, w_lw_dst;
    logic       w_dx_md, w_load_use, w_start, w_fsm_stall;

    assign w_xm_dst = dest(xm_insn);
    assign w_mw_dst = dest(mw_insn);
    assign w_dx_a   = src_a(dx_insn);
    assign w_dx_b   = src_b(dx_insn);
    assign w_fd_a   = src_a(fd_insn);
    assign w_fd_b   = src_b(fd_insn);
    assign w_lw_dst = (dx_insn[31:27] == 5'b01000) ? dx_insn[26:22] : 5'd0;

    assign w_dx_md     = dx_insn[31:27] == 5'b00000 && dx_insn[6:3] == 4'b0011;
    assign w_load_use  = w_lw_dst != 5'd0 && (w_fd_a == w_lw_dst || w_fd_b == w_lw_dst);
    assign w_start     = r_state == IDLE && w_dx_md;
    assign w_fsm_stall = w_start || r_state == BUSY;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
        end else if (r_state == IDLE) begin
            if (w_dx_md) begin
                r_state <= BUSY;
                r_cnt   <= 6'd1;
            end
        end else if (r_state == BUSY) begin
            if (r_cnt == 6'(MD_LATENCY)) r_state <= DONE;
            else r_cnt <= r_cnt + 6'd1;
        end else begin
            r_state <= IDLE;
        end
    end

    // Everything is forced low while reset is asserted, including combinational paths.
    assign stall_fd        = !reset && (w_fsm_stall || w_load_use);
    assign stall_dx        = !reset && w_fsm_stall;
    assign bubble_dx       = !reset && w_load_use && !w_fsm_stall;
    assign md_start        = !reset && w_start;
    assign md_op           = !reset && w_start && dx_insn[2];
    assign md_busy         = !reset && r_state == BUSY;
    assign md_result_valid = !reset && r_state == DONE;
    assign sel_a = reset || w_dx_a == 5'd0 ? 2'b00 : w_dx_a == w_xm_dst ? 2'b01 :
                   w_dx_a == w_mw_dst ? 2'b10 : 2'b00;
    assign sel_b = reset || w_dx_b == 5'd0 ? 2'b00 : w_dx_b == w_xm_dst ? 2'b01 :
                   w_dx_b == w_mw_dst ? 2'b10 : 2'b00;
endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard controller for the 5-stage 32-bit core.
- Decodes the F/D, D/X, X/M and M/W instruction latches.
- Drives the operand-bypass mux selects for the D/X stage and the load-use stall/bubble.
- Sequences the shared multi-cycle mul/div unit with an IDLE/BUSY/DONE FSM and cycle counter, freezing the front of the pipe while the unit is occupied.

Parameters:
MD_LATENCY, 32, cycles the mul/div unit needs after md_start before its result is valid; legal range 1..63.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
fd_insn  in  32  instruction in F/D latch
dx_insn  in  32  instruction in D/X latch
xm_insn  in  32  instruction in X/M latch
mw_insn  in  32  instruction in M/W latch
stall_fd  out  1  hold PC and F/D latch
stall_dx  out  1  hold D/X latch
bubble_dx  out  1  load nop (32'h0) into D/X at next edge
md_start  out  1  one-cycle start pulse to mul/div unit
md_op  out  1  0 = mul, 1 = div; valid with md_start
md_busy  out  1  FSM in BUSY
md_result_valid  out  1  X/M must capture mul/div result this cycle
sel_a  out  2  operand A source: 00 regfile, 01 X/M result, 10 M/W writeback
sel_b  out  2  operand B source, same encoding

Behaviour:
- Fields: opcode [31:27], rd [26:22], rs1 [21:17], rs2 [16:12], ALU op [6:2].
- Writers and their destination:
  - ALU (00000), addi (00101), lw (01000) write rd.
  - jal (00011) writes r31.
  - setx (10101) writes r30.
  - All others write nothing.
  - Destination r0 is never a writer.
- Source A register:
  - rs1 for ALU, addi, sw (00111), lw, bne (00010), blt (00110).
  - rd for jr (00100).
  - r30 for bex (10110).
  - None otherwise.
- Source B register:
  - rs2 for ALU.
  - rd for sw, bne, blt.
  - None otherwise.
- Bypass selects (combinational, on dx_insn sources):
  - 01 if the X/M writer destination matches the source.
  - Else 10 if the M/W writer destination matches.
  - Else 00.
  - X/M takes priority over M/W.
  - No source, or source r0, gives 00.
- Load-use: dx is lw with dest != r0, and the fd_insn source A or B equals that dest → stall_fd=1, bubble_dx=1. Combinational.
- Mul/div detect: dx opcode 00000 with ALU op 00110 (mul) or 00111 (div).
- FSM, states IDLE/BUSY/DONE, counter cnt:
  - IDLE:
    - If dx is mul/div: md_start=1, md_op set, stall_fd=1, stall_dx=1.
    - Next state BUSY, cnt←1.
    - Otherwise stay IDLE.
  - BUSY:
    - stall_fd=1, stall_dx=1, md_busy=1.
    - If cnt==MD_LATENCY, next state DONE; else cnt←cnt+1.
  - DONE:
    - md_result_valid=1; stalls low, so D/X advances.
    - Next state IDLE unconditionally, so a back-to-back mul/div is caught in the following IDLE cycle.
  - Total front-end freeze per mul/div: MD_LATENCY+1 cycles, then one DONE cycle.
- Priority:
  - While the FSM is stalling, bubble_dx is forced 0; D/X holds rather than bubbles.
  - Load-use and mul/div cannot coexist in dx, but the FSM stall wins regardless.
- Reset, including mid-BUSY:
  - Next edge: state IDLE, cnt 0.
  - All registered state cleared.
  - Outputs low while reset is high: stall_fd, stall_dx, bubble_dx, md_start, md_op, md_busy, md_result_valid = 0; sel_a = sel_b = 00.
- Nop (32'h0) is ALU add into r0: generates no forwarding and no stall.

Test Plan:
- Forwarding priority: xm = add r5,r1,r2; mw = addi r5,r3,4; dx = add r7,r5,r5 → sel_a=01, sel_b=01. With xm replaced by nop → sel_a=sel_b=10.
- r0 and implicit registers: dx = add r1,r0,r0 with xm writing r0 → sel_a=sel_b=00. xm = setx, dx = bex → sel_a=01. mw = jal, dx = jr r31 → sel_a=10.
- Load-use: dx = lw r4,0(r2); fd = add r6,r4,r1 → stall_fd=1, bubble_dx=1 for exactly one cycle. fd = sw r4,0(r3) (reads rd) → same response.
- Mul timing, MD_LATENCY=4:
  - dx = mul r3,r1,r2 → md_start pulse in cycle 0, md_op=0.
  - md_busy cycles 1–4; stall_fd/stall_dx high cycles 0–4.
  - md_result_valid in cycle 5 only.
  - Back-to-back div then starts in cycle 6 with md_op=1.
- Reset during BUSY (cycle 2 of 4) → next cycle: state IDLE, all outputs 0. A held mul in dx restarts with a fresh md_start after reset drops.
- MD_LATENCY=1 boundary: sequence is IDLE(start) → BUSY (one cycle) → DONE; 2 stall cycles total, then md_result_valid.
